// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: classifies each access as RAM, MMIO or fault, drives RAM traffic to a
// line-wide dcache port, and queues MMIO byte writes in an in-order FIFO that drains to handshake channels.
module mem_access_unit #(
  parameter int unsigned LINE_BYTES = 16,
  parameter logic [31:0] RAM_BASE   = 32'h8000_0000,
  parameter logic [31:0] RAM_SIZE   = 32'h0004_0000,
  parameter logic [31:0] MMIO_BASE  = 32'he000_0000,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  input  logic                    op_load,
  input  logic                    op_store,
  input  logic [2:0]              op_funct3,
  input  logic [31:0]             op_addr,
  input  logic [31:0]             op_wdata,
  input  logic                    flush,
  output logic                    stall_req,
  output logic                    dc_valid,
  input  logic                    dc_ready,
  output logic                    dc_we,
  output logic [31:0]             dc_addr,
  output logic [LINE_BYTES-1:0]   dc_wmask,
  output logic [8*LINE_BYTES-1:0] dc_wdata,
  input  logic [8*LINE_BYTES-1:0] dc_rdata,
  output logic [NUM_CH-1:0]       mmio_valid,
  input  logic [NUM_CH-1:0]       mmio_ready,
  output logic [7:0]              mmio_data,
  output logic                    res_valid,
  output logic [31:0]             res_data,
  output logic                    fault,
  output logic [31:0]             fault_addr
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [31:0]       ram_off, mmio_off;
  logic              is_ram, is_mmio, is_access, f3_ok, misalign, fault_now;
  logic              ram_op, mmio_st, mmio_ld, push, pop, full, empty, ld_accept;
  logic [CH_W-1:0]   ch_sel, head_ch;
  logic [OFF_W-1:0]  off;
  logic [LINE_BYTES-1:0] wmask_base;
  logic [LINE_W-1:0] wdata_base;

  logic [CH_W+7:0]   fifo_mem [FIFO_DEPTH];
  logic [CH_W+7:0]   head;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              ld_pend_reg, mmio_rd_reg, mmio_stat_reg, fault_reg;
  logic [OFF_W-1:0]  ld_off_reg;
  logic [2:0]        ld_f3_reg;
  logic [31:0]       fault_addr_reg;
  logic [3:0][7:0]   ld_bytes;
  logic [31:0]       ld_word;

  // Address classification; RAM wins if the two windows were ever configured to overlap
  assign ram_off   = op_addr - RAM_BASE;
  assign mmio_off  = op_addr - MMIO_BASE;
  assign is_ram    = (op_addr >= RAM_BASE) && (ram_off < RAM_SIZE);
  assign is_mmio   = !is_ram && (op_addr[1:0] == 2'b00) && ((mmio_off >> 2) < NUM_CH);
  assign ch_sel    = mmio_off[CH_W+1:2];
  assign off       = op_addr[OFF_W-1:0];
  assign is_access = op_valid && (op_load || op_store);

  always_comb begin
    f3_ok = 1'b0;
    if (op_store) f3_ok = (op_funct3 == 3'b000) || (op_funct3 == 3'b001) || (op_funct3 == 3'b010);
    else          f3_ok = (op_funct3 == 3'b000) || (op_funct3 == 3'b001) || (op_funct3 == 3'b010) ||
                          (op_funct3 == 3'b100) || (op_funct3 == 3'b101);
  end

  assign misalign  = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                     ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
  assign fault_now = is_access && (!f3_ok || misalign || !(is_ram || is_mmio));
  assign ram_op    = is_access && is_ram && !fault_now;
  assign mmio_st   = is_access && op_store && is_mmio && !fault_now;
  assign mmio_ld   = is_access && op_load && is_mmio && !fault_now;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop   = |(mmio_valid & mmio_ready);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the store
  assign push  = mmio_st && (!full || pop);

  assign stall_req = (dc_valid && !dc_ready) || (mmio_st && full && !pop);

  assign dc_valid  = ram_op;
  assign dc_we     = ram_op && op_store;
  assign dc_addr   = ram_op ? op_addr : '0;
  assign ld_accept = dc_valid && dc_ready && !dc_we;

  always_comb begin
    wmask_base = '0;
    wdata_base = '0;
    if (dc_we) begin
      case (op_funct3[1:0])
        2'b00:   wmask_base[3:0] = 4'h1;
        2'b01:   wmask_base[3:0] = 4'h3;
        default: wmask_base[3:0] = 4'hF;
      endcase
      wdata_base[31:0] = op_wdata;
    end
    dc_wmask = wmask_base << off;
    dc_wdata = wdata_base << {off, 3'b000};
  end

  assign head      = fifo_mem[rd_ptr_reg];
  assign head_ch   = head[CH_W+7:8];
  assign mmio_data = empty ? 8'h00 : head[7:0];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    assign mmio_valid[gi] = !empty && (head_ch == CH_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {ch_sel, op_wdata[7:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      ld_pend_reg    <= 1'b0;
      ld_off_reg     <= '0;
      ld_f3_reg      <= '0;
      mmio_rd_reg    <= 1'b0;
      mmio_stat_reg  <= 1'b0;
      fault_reg      <= 1'b0;
      fault_addr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      ld_pend_reg <= !flush && ld_accept;
      if (ld_accept) begin
        ld_off_reg <= off;
        ld_f3_reg  <= op_funct3;
      end
      mmio_rd_reg   <= !flush && mmio_ld;
      mmio_stat_reg <= !full;
      fault_reg     <= !flush && fault_now;
      if (fault_now) fault_addr_reg <= op_addr;
    end
  end

  // Aligned accesses never cross the line, so byte lanes simply wrap within it
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign ld_bytes[gi] = dc_rdata[{ld_off_reg + OFF_W'(gi), 3'b000} +: 8];
  end
  assign ld_word = ld_bytes;

  always_comb begin
    res_data = '0;
    if (ld_pend_reg) begin
      case (ld_f3_reg)
        3'b000:  res_data = {{24{ld_word[7]}}, ld_word[7:0]};
        3'b001:  res_data = {{16{ld_word[15]}}, ld_word[15:0]};
        3'b100:  res_data = {24'b0, ld_word[7:0]};
        3'b101:  res_data = {16'b0, ld_word[15:0]};
        default: res_data = ld_word;
      endcase
    end else if (mmio_rd_reg) begin
      res_data = {31'b0, mmio_stat_reg};
    end
  end

  assign res_valid  = ld_pend_reg || mmio_rd_reg;
  assign fault      = fault_reg;
  assign fault_addr = fault_addr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: results are checked against a scoreboard queue filled at drive time,
// MMIO bytes against an expected-order queue.
module tb_mem_access_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid, op_load, op_store, flush, dc_ready;
  logic [2:0]   op_funct3;
  logic [31:0]  op_addr, op_wdata;
  logic         stall_req, dc_valid, dc_we, res_valid, fault;
  logic [31:0]  dc_addr, res_data, fault_addr;
  logic [15:0]  dc_wmask;
  logic [127:0] dc_wdata, dc_rdata;
  logic [1:0]   mmio_valid, mmio_ready;
  logic [7:0]   mmio_data;

  localparam logic [127:0] LINE = 128'hF0E1D2C3_B4A59687_78695A4B_80A2B1C0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
    .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata), .flush(flush),
    .stall_req(stall_req), .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_we(dc_we),
    .dc_addr(dc_addr), .dc_wmask(dc_wmask), .dc_wdata(dc_wdata), .dc_rdata(dc_rdata),
    .mmio_valid(mmio_valid), .mmio_ready(mmio_ready), .mmio_data(mmio_data),
    .res_valid(res_valid), .res_data(res_data), .fault(fault), .fault_addr(fault_addr)
  );

  typedef struct packed {
    logic        flt;
    logic [31:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input logic flt, input logic [31:0] v);
    exp_q.push_back({flt, v});
  endtask

  // One clock; results of the op presented before the edge are compared just after it
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_present", res_valid | fault, 1'b1);
      if (res_valid | fault) begin
        chk("sb_kind", fault, e.flt);
        chk("sb_value", fault ? fault_addr : res_data, e.val);
      end
    end else begin
      chk("sb_idle", {res_valid, fault}, 2'b00);
    end
    $display("t=%0t res_valid=%0b res_data=%h fault=%0b fault_addr=%h mmio_valid=%b mmio_data=%h",
             $time, res_valid, res_data, fault, fault_addr, mmio_valid, mmio_data);
  endtask

  task automatic op(input logic ld, input logic st, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] d);
    op_valid = 1'b1; op_load = ld; op_store = st; op_funct3 = f3; op_addr = a; op_wdata = d;
    #1;
  endtask

  task automatic idle();
    op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0; op_funct3 = 3'b0; op_addr = '0; op_wdata = '0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; dc_ready = 1'b1; dc_rdata = LINE; mmio_ready = 2'b00;
    idle();
    rst = 1'b1;
    #1;
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_dc_valid", dc_valid, 1'b0);
    chk("rst_mmio_valid", mmio_valid, 2'b00);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;

    // Loads: sign/zero extension and lane selection
    op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0);
    chk("lb_dc_valid", dc_valid, 1'b1);
    chk("lb_dc_we", dc_we, 1'b0);
    chk("lb_dc_addr", dc_addr, 32'h8000_0003);
    chk("lb_stall", stall_req, 1'b0);
    expect_res(1'b0, 32'hFFFF_FF80); cyc();
    op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0); expect_res(1'b0, 32'h0000_0080); cyc();
    op(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0); expect_res(1'b0, 32'hFFFF_80A2); cyc();
    op(1'b1, 1'b0, 3'b101, 32'h8000_000E, 32'h0); expect_res(1'b0, 32'h0000_F0E1); cyc();
    op(1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0); expect_res(1'b0, 32'hB4A5_9687); cyc();

    // Stores: mask and data placement
    op(1'b0, 1'b1, 3'b001, 32'h8000_0006, 32'h0000_1234);
    chk("sh_we", dc_we, 1'b1);
    chk("sh_wmask", dc_wmask, 16'h00C0);
    chk("sh_wdata_field", dc_wdata[63:48], 16'h1234);
    chk("sh_wdata", dc_wdata, 128'h1234 << 48);
    cyc();
    op(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF);
    chk("sw_wmask", dc_wmask, 16'h00F0);
    chk("sw_wdata", dc_wdata, 128'hDEAD_BEEF << 32);
    cyc();
    op(1'b0, 1'b1, 3'b000, 32'h8000_000F, 32'h0000_00A5);
    chk("sb_wmask", dc_wmask, 16'h8000);
    chk("sb_wdata", dc_wdata, 128'hA5 << 120);
    cyc();

    // Faults
    op(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0);
    chk("mis_dc_valid", dc_valid, 1'b0);
    chk("mis_stall", stall_req, 1'b0);
    expect_res(1'b1, 32'h8000_0002); cyc();
    op(1'b1, 1'b0, 3'b010, 32'h8004_0000, 32'h0); expect_res(1'b1, 32'h8004_0000); cyc();
    op(1'b1, 1'b0, 3'b000, 32'h7FFF_FFFF, 32'h0); expect_res(1'b1, 32'h7FFF_FFFF); cyc();
    op(1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0); expect_res(1'b1, 32'h8000_0000); cyc();
    op(1'b0, 1'b1, 3'b000, 32'hE000_0008, 32'h0);
    chk("badch_no_mmio", mmio_valid, 2'b00);
    expect_res(1'b1, 32'hE000_0008); cyc();
    op(1'b0, 1'b1, 3'b010, 32'hE000_0002, 32'h0); expect_res(1'b1, 32'hE000_0002); cyc();

    // Flush kills the coming result and fault
    flush = 1'b1;
    op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0); cyc();
    op(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0); cyc();
    flush = 1'b0;

    // dcache back-pressure: three stalled cycles then one accept
    dc_ready = 1'b0;
    op(1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req_hold", stall_req, 1'b1);
      chk("stall_dc_valid", dc_valid, 1'b1);
      cyc();
    end
    dc_ready = 1'b1;
    #1;
    chk("stall_release", stall_req, 1'b0);
    expect_res(1'b0, 32'h80A2_B1C0); cyc();
    idle(); cyc();

    // MMIO FIFO fill to full, fifth store stalls until the first pop
    mmio_ready = 2'b00;
    op(1'b0, 1'b1, 3'b000, 32'hE000_0000, 32'hAB00_0011);
    chk("mmio_no_bypass", mmio_valid, 2'b00);
    mq.push_back(8'h11); cyc();
    for (int i = 1; i < 4; i++) begin
      op(1'b0, 1'b1, 3'b000, 32'hE000_0000, 32'hAB00_0011 + i);
      chk("mmio_fill_stall", stall_req, 1'b0);
      mq.push_back(8'(8'h11 + i)); cyc();
    end
    chk("mmio_head_valid", mmio_valid, 2'b01);
    chk("mmio_head_data", mmio_data, 8'h11);
    op(1'b1, 1'b0, 3'b010, 32'hE000_0004, 32'h0);
    chk("mmio_ld_stall", stall_req, 1'b0);
    expect_res(1'b0, 32'h0); cyc();
    op(1'b0, 1'b1, 3'b000, 32'hE000_0000, 32'h0000_0015);
    chk("mmio_full_stall", stall_req, 1'b1);
    cyc();
    chk("mmio_full_stall2", stall_req, 1'b1);
    mmio_ready = 2'b01;
    #1;
    chk("mmio_stall_clears", stall_req, 1'b0);
    chk("mmio_pop_data", mmio_data, mq.pop_front());
    mq.push_back(8'h15); cyc();
    idle();
    for (int i = 0; i < 8 && mq.size() != 0; i++) begin
      chk("drain_valid", mmio_valid, 2'b01);
      chk("drain_data", mmio_data, mq.pop_front());
      cyc();
    end
    chk("drain_done", mq.size(), 0);
    chk("drain_empty", mmio_valid, 2'b00);
    mmio_ready = 2'b00;
    op(1'b1, 1'b0, 3'b010, 32'hE000_0000, 32'h0); expect_res(1'b0, 32'h1); cyc();

    // Per-channel routing and in-order drain
    op(1'b0, 1'b1, 3'b000, 32'hE000_0004, 32'h0000_00A1); cyc();
    op(1'b0, 1'b1, 3'b001, 32'hE000_0000, 32'h0000_77B0); cyc();
    idle();
    chk("ch1_valid", mmio_valid, 2'b10);
    chk("ch1_data", mmio_data, 8'hA1);
    mmio_ready = 2'b01; cyc();
    chk("ch1_wrong_ready", mmio_valid, 2'b10);
    mmio_ready = 2'b10; cyc();
    chk("ch0_valid", mmio_valid, 2'b01);
    chk("ch0_data", mmio_data, 8'hB0);
    mmio_ready = 2'b00;
    op(1'b0, 1'b1, 3'b000, 32'hE000_0004, 32'h0000_00C1); cyc();
    idle();

    // Async reset mid-drain
    #2 rst = 1'b1;
    #1;
    chk("arst_mmio_valid", mmio_valid, 2'b00);
    chk("arst_mmio_data", mmio_data, 8'h00);
    #1 rst = 1'b0;
    mmio_ready = 2'b11;
    cyc();
    chk("arst_fifo_empty", mmio_valid, 2'b00);
    op(1'b1, 1'b0, 3'b010, 32'hE000_0004, 32'h0); expect_res(1'b0, 32'h1); cyc();
    idle(); cyc();
    chk("arst_still_empty", mmio_valid, 2'b00);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
